// File: rtl/height_frame_scheduler_pkg.sv
// Shared definitions for the raycaster column-height scheduler.
// Holds the display geometry used as parameter defaults and the encoding
// of the per-frame controller states.
package height_frame_scheduler_pkg;

  localparam int WIDTH    = 640;  // visible columns, one ray per column
  localparam int HEIGHT   = 480;  // visible rows
  localparam int HEIGHT_W = 9;    // bits needed for a height of 0..HEIGHT-1
  localparam int COL_W    = 10;   // column address width

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RENDER = 2'd1,
    ST_WAIT   = 2'd2,
    ST_SWAP   = 2'd3
  } hfs_state_t;

endpackage

// File: rtl/height_pingpong_ram.sv
// Two-bank column-height store for the frame scheduler.
// One write port and one registered read port, each with its own bank
// select, so the producer fills one bank while the renderer reads the other.
// The banks have no reset; only the read register does.
// Ports:
//   clk      in   clock
//   reset    in   asynchronous active-high reset (read register only)
//   wr_en    in   write strobe
//   wr_bank  in   bank receiving the write
//   wr_addr  in   write column
//   wr_data  in   write value
//   rd_bank  in   bank being read
//   rd_addr  in   read column; addresses at or beyond DEPTH read as 0
//   rd_data  out  read value, one cycle after rd_addr
module height_pingpong_ram #(
  parameter int DEPTH  = 640,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic              wr_bank,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_bank,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam logic [ADDR_W-1:0] DEPTH_C = ADDR_W'(DEPTH);

  logic [DATA_W-1:0] bank0 [0:DEPTH-1];
  logic [DATA_W-1:0] bank1 [0:DEPTH-1];

  // Callers only raise wr_en for in-range addresses.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (wr_bank) bank1[wr_addr] <= wr_data;
      else         bank0[wr_addr] <= wr_data;
    end
  end

  // Registered read stage
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data <= '0;
    end else if (rd_addr < DEPTH_C) begin
      rd_data <= rd_bank ? bank1[rd_addr] : bank0[rd_addr];
    end else begin
      rd_data <= '0;
    end
  end

endmodule

// File: rtl/height_frame_scheduler.sv
// Per-frame sequencer for the raycaster column-height store.
// Starts one ray sweep per frame, writes saturated heights into the back
// bank of a ping-pong store, and swaps banks only at a frame end that
// follows a completed sweep, so the renderer never sees a partial frame.
// A frame end arriving mid-sweep is an overrun: no swap, sweep continues.
// Optional build macro HFS_OVERRUN_CNT_EN adds the overrun_cnt output.
// Ports:
//   clk              in   clock
//   reset            in   asynchronous active-high reset
//   frame_end        in   1-cycle pulse at the last visible pixel
//   height_found     in   strobe: ray_index / wall_height valid
//   ray_index        in   column of the current result
//   wall_height      in   computed wall height
//   render_start     out  1-cycle pulse restarting the sweep at column 0
//   rd_addr          in   renderer column address
//   rd_data          out  height from the front bank, 1-cycle latency
//   data_initialised out  sticky, set once a complete frame is displayable
//   overrun_cnt      out  (HFS_OVERRUN_CNT_EN only) saturating overrun count
//   busy             out  high while a sweep is in progress
module height_frame_scheduler
  import height_frame_scheduler_pkg::*;
#(
  parameter int NUM_COLS   = WIDTH,
  parameter int H_IN_W     = 10,
  parameter int H_OUT_W    = HEIGHT_W,
  parameter int MAX_HEIGHT = HEIGHT - 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_end,
  input  logic               height_found,
  input  logic [COL_W-1:0]   ray_index,
  input  logic [H_IN_W-1:0]  wall_height,
  output logic               render_start,
  input  logic [COL_W-1:0]   rd_addr,
  output logic [H_OUT_W-1:0] rd_data,
  output logic               data_initialised,
`ifdef HFS_OVERRUN_CNT_EN
  output logic [7:0]         overrun_cnt,
`endif
  output logic               busy
);

  localparam logic [COL_W-1:0] NUM_COLS_C = COL_W'(NUM_COLS);
  localparam logic [COL_W-1:0] LAST_COL   = COL_W'(NUM_COLS - 1);

  function automatic logic [H_OUT_W-1:0] sat_height(input logic [H_IN_W-1:0] h);
    logic [H_OUT_W-1:0] r;
    if (h > H_IN_W'(MAX_HEIGHT)) r = H_OUT_W'(MAX_HEIGHT);
    else                         r = h[H_OUT_W-1:0];
    return r;
  endfunction

  hfs_state_t state, next_state;
  logic       front_bank;
  logic       wr_en;
  logic       swap_now;
  logic       start_d;
  logic       last_col_hit;

  assign last_col_hit = height_found && (ray_index == LAST_COL);
  assign busy         = (state == ST_RENDER);

  always_comb begin
    next_state = state;
    wr_en      = 1'b0;
    swap_now   = 1'b0;
    start_d    = 1'b0;
    case (state)
      ST_IDLE: begin
        next_state = ST_RENDER;
        start_d    = 1'b1;
      end
      ST_RENDER: begin
        wr_en = height_found && (ray_index < NUM_COLS_C);
        // A frame end coinciding with the last column counts as on time.
        if (last_col_hit) begin
          if (frame_end) begin
            next_state = ST_SWAP;
            swap_now   = 1'b1;
          end else begin
            next_state = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (frame_end) begin
          next_state = ST_SWAP;
          swap_now   = 1'b1;
        end
      end
      ST_SWAP: begin
        next_state = ST_RENDER;
        start_d    = 1'b1;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // The bank flip is registered on entry to SWAP so the read register
  // picks up the new frame on the very next edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= ST_IDLE;
      front_bank       <= 1'b0;
      data_initialised <= 1'b0;
      render_start     <= 1'b0;
    end else begin
      state        <= next_state;
      render_start <= start_d;
      if (swap_now) begin
        front_bank       <= ~front_bank;
        data_initialised <= 1'b1;
      end
    end
  end

`ifdef HFS_OVERRUN_CNT_EN
  logic overrun_evt;
  assign overrun_evt = (state == ST_RENDER) && frame_end && !last_col_hit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overrun_cnt <= 8'd0;
    end else if (overrun_evt && (overrun_cnt != 8'hFF)) begin
      overrun_cnt <= overrun_cnt + 8'd1;
    end
  end
`endif

  height_pingpong_ram #(
    .DEPTH  (NUM_COLS),
    .ADDR_W (COL_W),
    .DATA_W (H_OUT_W)
  ) u_ram (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_bank (~front_bank),
    .wr_addr (ray_index),
    .wr_data (sat_height(wall_height)),
    .rd_bank (front_bank),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_height_frame_scheduler.sv
// Bench for height_frame_scheduler: scenario tasks drive sweeps and frame
// ends; read requests push the expected height into a queue and a monitor
// pops and compares when the registered read data is due.
module tb_height_frame_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       frame_end = 1'b0;
  logic       height_found = 1'b0;
  logic [9:0] ray_index = '0;
  logic [9:0] wall_height = '0;
  logic [9:0] rd_addr = '0;
  logic       render_start;
  logic [8:0] rd_data;
  logic       data_initialised;
  logic       busy;
`ifdef HFS_OVERRUN_CNT_EN
  logic [7:0] overrun_cnt;
`endif

  height_frame_scheduler dut (
    .clk              (clk),
    .reset            (reset),
    .frame_end        (frame_end),
    .height_found     (height_found),
    .ray_index        (ray_index),
    .wall_height      (wall_height),
    .render_start     (render_start),
    .rd_addr          (rd_addr),
    .rd_data          (rd_data),
    .data_initialised (data_initialised),
`ifdef HFS_OVERRUN_CNT_EN
    .overrun_cnt      (overrun_cnt),
`endif
    .busy             (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [8:0] exp_q [$];
  string      nm_q  [$];
  logic       rd_req = 1'b0;
  logic       rd_vld = 1'b0;
  logic [8:0] mon_exp;
  string      mon_nm;

  // Reference image of both banks, written only when the scenario expects a store.
  logic [8:0] model_mem [0:1][0:639];
  int         front_m = 0;

  function automatic logic [8:0] sat_m(input int h);
    return (h > 479) ? 9'd479 : 9'(h);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input int idx, input int h, input bit wr, input bit fe);
    height_found = 1'b1;
    ray_index    = 10'(idx);
    wall_height  = 10'(h);
    frame_end    = fe;
    tick();
    height_found = 1'b0;
    frame_end    = 1'b0;
    if (wr) model_mem[1 - front_m][idx] = sat_m(h);
  endtask

  task automatic rd_issue(input string nm, input int addr, input logic [8:0] e);
    exp_q.push_back(e);
    nm_q.push_back(nm);
    rd_addr = 10'(addr);
    rd_req  = 1'b1;
  endtask

  task automatic rd_read(input string nm, input int addr);
    rd_issue(nm, addr, (addr < 640) ? model_mem[front_m][addr] : 9'd0);
    tick();
    rd_req = 1'b0;
  endtask

  // Read response monitor
  always @(posedge clk) rd_vld <= rd_req;

  always @(negedge clk) begin
    if (rd_vld) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL scoreboard_empty: rd_data=%0d with no expected value", rd_data);
      end else begin
        mon_exp = exp_q.pop_front();
        mon_nm  = nm_q.pop_front();
        if (rd_data !== mon_exp) begin
          n_bad++;
          $display("FAIL %s: rd_data=%0d expected %0d", mon_nm, rd_data, mon_exp);
        end
      end
    end
  end

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    n_cmp++; if (render_start !== 1'b0) begin n_bad++; $display("FAIL rst_render_start: got %b want 0", render_start); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_cmp++; if (data_initialised !== 1'b0) begin n_bad++; $display("FAIL rst_data_init: got %b want 0", data_initialised); end
    n_cmp++; if (rd_data !== 9'd0) begin n_bad++; $display("FAIL rst_rd_data: got %0d want 0", rd_data); end
    reset = 1'b0;
    tick();
    n_cmp++; if (render_start !== 1'b1) begin n_bad++; $display("FAIL start_pulse: got %b want 1", render_start); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL start_busy: got %b want 1", busy); end
    tick();
    n_cmp++; if (render_start !== 1'b0) begin n_bad++; $display("FAIL start_pulse_width: got %b want 0", render_start); end
  endtask

  task automatic test_first_sweep();
    for (int i = 0; i < 640; i++) begin
      strobe(i, 100, 1'b1, 1'b0);
      if (i == 638) begin
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL busy_before_last: got %b want 1", busy); end
      end
    end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL busy_after_last: got %b want 0", busy); end
    n_cmp++; if (data_initialised !== 1'b0) begin n_bad++; $display("FAIL data_init_before_swap: got %b want 0", data_initialised); end
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL wait_holds: got %b want 0", busy); end
  endtask

  task automatic test_swap();
    rd_addr   = 10'd5;
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
    front_m   = 1 - front_m;
    rd_issue("swap_addr5", 5, model_mem[front_m][5]);
    tick();
    rd_req = 1'b0;
    n_cmp++; if (data_initialised !== 1'b1) begin n_bad++; $display("FAIL swap_data_init: got %b want 1", data_initialised); end
    n_cmp++; if (render_start !== 1'b1) begin n_bad++; $display("FAIL swap_render_start: got %b want 1", render_start); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL swap_busy: got %b want 1", busy); end
  endtask

  task automatic test_overrun_and_sat();
    int h;
    for (int i = 0; i < 640; i++) begin
      h = (i == 10) ? 600 : (i == 11) ? 479 : 200 + (i % 100);
      strobe(i, h, 1'b1, i == 300);
      if (i == 300) begin
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL overrun_busy: got %b want 1", busy); end
`ifdef HFS_OVERRUN_CNT_EN
        n_cmp++; if (overrun_cnt !== 8'd1) begin n_bad++; $display("FAIL overrun_cnt: got %0d want 1", overrun_cnt); end
`endif
        rd_read("overrun_old_front", 300);
        strobe(700, 5, 1'b0, 1'b0);
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL oob_index_busy: got %b want 1", busy); end
      end
    end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL sweep2_done: got %b want 0", busy); end
    strobe(5, 7, 1'b0, 1'b0);
    rd_read("no_swap_before_fe", 10);
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
    front_m   = 1 - front_m;
    rd_issue("sat_600", 10, model_mem[front_m][10]);
    tick();
    rd_req = 1'b0;
    rd_read("sat_479", 11);
    rd_read("wait_strobe_ignored", 5);
    rd_read("sweep2_col300", 300);
    rd_read("addr_out_of_range", 700);
  endtask

  task automatic test_same_cycle();
    for (int i = 0; i < 639; i++) strobe(i, 300 + (i % 100), 1'b1, 1'b0);
    height_found = 1'b1;
    ray_index    = 10'd639;
    wall_height  = 10'd339;
    frame_end    = 1'b1;
    tick();
    height_found = 1'b0;
    model_mem[1 - front_m][639] = sat_m(339);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL same_cycle_swap_state: got busy %b want 0", busy); end
    front_m = 1 - front_m;
    rd_issue("same_cycle_col639", 639, model_mem[front_m][639]);
    tick();
    frame_end = 1'b0;
    rd_req    = 1'b0;
    n_cmp++; if (render_start !== 1'b1) begin n_bad++; $display("FAIL same_cycle_restart: got %b want 1", render_start); end
`ifdef HFS_OVERRUN_CNT_EN
    n_cmp++; if (overrun_cnt !== 8'd1) begin n_bad++; $display("FAIL no_overrun_on_time: got %0d want 1", overrun_cnt); end
`endif
  endtask

  task automatic test_reset_mid_sweep();
    for (int i = 0; i < 200; i++) strobe(i, 50, 1'b1, 1'b0);
    reset = 1'b1;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL async_rst_busy: got %b want 0", busy); end
    n_cmp++; if (data_initialised !== 1'b0) begin n_bad++; $display("FAIL async_rst_data_init: got %b want 0", data_initialised); end
    n_cmp++; if (rd_data !== 9'd0) begin n_bad++; $display("FAIL async_rst_rd_data: got %0d want 0", rd_data); end
`ifdef HFS_OVERRUN_CNT_EN
    n_cmp++; if (overrun_cnt !== 8'd0) begin n_bad++; $display("FAIL async_rst_overrun: got %0d want 0", overrun_cnt); end
`endif
    front_m = 0;
    tick();
    tick();
    reset     = 1'b0;
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
    n_cmp++; if (render_start !== 1'b1) begin n_bad++; $display("FAIL restart_pulse: got %b want 1", render_start); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL restart_busy: got %b want 1", busy); end
    rd_read("banks_kept_500", 500);
    rd_read("banks_kept_100", 100);
    for (int i = 0; i < 640; i++) strobe(i, 60 + (i % 10), 1'b1, 1'b0);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL sweep5_done: got %b want 0", busy); end
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
    front_m   = 1 - front_m;
    rd_issue("after_reset_col639", 639, model_mem[front_m][639]);
    tick();
    rd_req = 1'b0;
    n_cmp++; if (data_initialised !== 1'b1) begin n_bad++; $display("FAIL after_reset_data_init: got %b want 1", data_initialised); end
    rd_read("after_reset_col0", 0);
  endtask

  initial begin
    test_reset();
    test_first_sweep();
    test_swap();
    test_overrun_and_sat();
    test_same_cycle();
    test_reset_mid_sweep();
    tick();
    tick();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
